// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes that select zero-extension,
// the NOP encoding, instruction field bit positions, and the ext_op helper.
package mips_pkg;

    localparam logic [5:0]  OP_ANDI   = 6'h0C;
    localparam logic [5:0]  OP_ORI    = 6'h0D;
    localparam logic [5:0]  OP_XORI   = 6'h0E;
    localparam logic [5:0]  OP_LUI    = 6'h0F;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Logical immediates and LUI take a zero-extended immediate; everything else sign-extends.
    function automatic logic ext_op_of(input logic [5:0] opcode);
        logic sign_ext;
        sign_ext = 1'b1;
        if ((opcode == OP_ANDI) || (opcode == OP_ORI) ||
            (opcode == OP_XORI) || (opcode == OP_LUI)) begin
            sign_ext = 1'b0;
        end
        return sign_ext;
    endfunction

endpackage

// File: rtl/pipe_skid2.sv
// Generic 2-entry valid/ready buffer. Both in_ready and out_valid are
// registered, so the upstream producer is never throttled combinationally
// and out_valid never depends on out_ready. flush empties the buffer.
module pipe_skid2 #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Only DEPTH=2 is supported; pointers are 1 bit and wrap naturally.
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic             wr_ptr_reg, wr_ptr_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic [1:0]       count_reg, count_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             push, pop;
    logic [WIDTH-1:0] entry_data [2];

    assign push      = in_valid & in_ready_reg;
    assign pop       = out_valid_reg & out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = entry_data[rd_ptr_reg];

    // Next pointer/occupancy; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
            count_next  = 2'd0;
        end else begin
            if (push) wr_ptr_next = ~wr_ptr_reg;
            if (pop)  rd_ptr_next = ~rd_ptr_reg;
            if (push && !pop)      count_next = count_reg + 2'd1;
            else if (pop && !push) count_next = count_reg - 2'd1;
        end
    end

    // Control state; handshake flags are precomputed from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            in_ready_reg  <= (count_next < FULL_CNT);
            out_valid_reg <= (count_next != 2'd0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_entry
            logic [WIDTH-1:0] entry_reg;

            // Capture the offered word into the slot the write pointer names.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= in_data;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: buffers {pc, instr} from fetch in a 2-entry skid
// buffer and presents the oldest entry split into decode fields.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm_16,
    output logic        id_ext_op
);

    logic [63:0] head_data;

    pipe_skid2 #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_data   ({if_pc, if_instr}),
        .out_valid (id_valid),
        .out_ready (id_ready),
        .out_data  (head_data)
    );

    // An empty stage shows a NOP at RESET_PC so decode never sees stale data.
    assign id_pc     = id_valid ? head_data[63:32] : RESET_PC;
    assign id_instr  = id_valid ? head_data[31:0]  : INSTR_NOP;

    assign id_rs     = id_instr[RS_HI:RS_LO];
    assign id_rt     = id_instr[RT_HI:RT_LO];
    assign id_rd     = id_instr[RD_HI:RD_LO];
    assign id_imm_16 = id_instr[IMM_HI:IMM_LO];
    assign id_ext_op = ext_op_of(id_instr[OPCODE_HI:OPCODE_LO]);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
`timescale 1ns/1ps
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_imm_16;
    logic        id_ext_op;

    int errors = 0;
    int checks = 0;

    if_id_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_imm_16 (id_imm_16),
        .id_ext_op (id_ext_op)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Load an entry so reset has something to discard.
        if_valid = 1'b1; if_pc = 32'h0000_4000; if_instr = 32'h1234_5678;
        step();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1) begin
            errors++; $display("FAIL reset_preload id_valid got=%0b exp=1", id_valid);
        end
        #2; rst_n = 1'b0; #1;
        checks++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs if_ready=%0b id_valid=%0b exp 1/0", if_ready, id_valid);
        end
        checks++;
        if (id_instr !== 32'h0 || id_pc !== 32'h0000_3000) begin
            errors++; $display("FAIL reset_head instr=%h pc=%h exp 00000000/00003000", id_instr, id_pc);
        end
        checks++;
        if (id_rs !== 5'd0 || id_rt !== 5'd0 || id_rd !== 5'd0 || id_imm_16 !== 16'h0 || id_ext_op !== 1'b1) begin
            errors++; $display("FAIL reset_fields rs=%0d rt=%0d rd=%0d imm=%h ext=%0b exp 0/0/0/0000/1",
                               id_rs, id_rt, id_rd, id_imm_16, id_ext_op);
        end
        $display("reset: if_ready=%0b id_valid=%0b id_pc=%h id_instr=%h", if_ready, id_valid, id_pc, id_instr);
        #2; rst_n = 1'b1;
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release id_valid got=%0b exp=0", id_valid);
        end
    endtask

    task automatic test_single_push();
        if_valid = 1'b1; if_pc = 32'h0000_3000; if_instr = 32'h3C01_1234; id_ready = 1'b0;
        step();
        if_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h0000_3000 || id_instr !== 32'h3C01_1234) begin
                errors++; $display("FAIL single_head[%0d] valid=%0b pc=%h instr=%h exp 1/00003000/3c011234",
                                   k, id_valid, id_pc, id_instr);
            end
            checks++;
            if (id_imm_16 !== 16'h1234 || id_rt !== 5'd1 || id_rs !== 5'd0 || id_rd !== 5'd2 || id_ext_op !== 1'b0) begin
                errors++; $display("FAIL single_fields[%0d] imm=%h rt=%0d rs=%0d rd=%0d ext=%0b exp 1234/1/0/2/0",
                                   k, id_imm_16, id_rt, id_rs, id_rd, id_ext_op);
            end
            $display("single[%0d]: id_valid=%0b id_pc=%h id_instr=%h", k, id_valid, id_pc, id_instr);
            step();
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop id_valid got=%0b exp=0", id_valid);
        end
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0000_3004; if_instr = 32'h8C22_FFFF;
        step();
        checks++;
        if (if_ready !== 1'b1 || id_instr !== 32'h8C22_FFFF) begin
            errors++; $display("FAIL fill_one if_ready=%0b instr=%h exp 1/8c22ffff", if_ready, id_instr);
        end
        if_pc = 32'h0000_3008; if_instr = 32'h2021_0004;
        step();
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full if_ready got=%0b exp=0", if_ready);
        end
        if_pc = 32'h0000_300C; if_instr = 32'h2003_0005;
        step(); step();
        checks++;
        if (if_ready !== 1'b0 || id_instr !== 32'h8C22_FFFF || id_pc !== 32'h0000_3004) begin
            errors++; $display("FAIL fill_hold if_ready=%0b instr=%h pc=%h exp 0/8c22ffff/00003004",
                               if_ready, id_instr, id_pc);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_instr !== 32'h2021_0004 || id_pc !== 32'h0000_3008 || id_imm_16 !== 16'h0004 || id_ext_op !== 1'b1) begin
            errors++; $display("FAIL fill_pop instr=%h pc=%h imm=%h ext=%0b exp 20210004/00003008/0004/1",
                               id_instr, id_pc, id_imm_16, id_ext_op);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL fill_ready_after_pop if_ready got=%0b exp=1", if_ready);
        end
        $display("fill: head=%h if_ready=%0b", id_instr, if_ready);
        step();  // held offer 2003_0005 now accepted
        if_valid = 1'b0;
        checks++;
        if (if_ready !== 1'b0 || id_instr !== 32'h2021_0004) begin
            errors++; $display("FAIL fill_refill if_ready=%0b instr=%h exp 0/20210004", if_ready, id_instr);
        end
        id_ready = 1'b1;
        step();
        checks++;
        if (id_instr !== 32'h2003_0005 || id_pc !== 32'h0000_300C) begin
            errors++; $display("FAIL fill_third instr=%h pc=%h exp 20030005/0000300c", id_instr, id_pc);
        end
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            errors++; $display("FAIL fill_drain valid=%0b if_ready=%0b exp 0/1", id_valid, if_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_pc    = 32'h0000_3000 + 32'(4 * i);
            exp_instr = 32'h2000_0000 | 32'(i);
            if_valid = 1'b1; if_pc = exp_pc; if_instr = exp_instr;
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
                errors++; $display("FAIL stream[%0d] valid=%0b pc=%h instr=%h exp 1/%h/%h",
                                   i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
            end
            checks++;
            if (if_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d] if_ready got=%0b exp=1", i, if_ready);
            end
            $display("stream[%0d]: id_pc=%h id_instr=%h if_ready=%0b", i, id_pc, id_instr, if_ready);
        end
        if_valid = 1'b0;
        step();
        id_ready = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end id_valid got=%0b exp=0", id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0000_5000; if_instr = 32'h2001_0001;
        step();
        if_pc = 32'h0000_5004; if_instr = 32'h2002_0002;
        step();
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL flush_full if_ready got=%0b exp=0", if_ready);
        end
        flush = 1'b1; if_pc = 32'h0000_5008; if_instr = 32'h2003_0003;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_pc !== 32'h0000_3000 || id_instr !== 32'h0) begin
            errors++; $display("FAIL flush_full_empty valid=%0b if_ready=%0b pc=%h instr=%h exp 0/1/00003000/00000000",
                               id_valid, if_ready, id_pc, id_instr);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_ghost id_valid got=%0b exp=0", id_valid);
        end
        // Flush at count=1 with a push that would otherwise be accepted.
        if_valid = 1'b1; if_pc = 32'h0000_6000; if_instr = 32'h2004_0004;
        step();
        flush = 1'b1; if_pc = 32'h0000_6004; if_instr = 32'h2005_0005;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            errors++; $display("FAIL flush_drop_push valid=%0b if_ready=%0b exp 0/1", id_valid, if_ready);
        end
        if_valid = 1'b1; if_pc = 32'h0000_7000; if_instr = 32'h2006_0006;
        step();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0000_7000 || id_instr !== 32'h2006_0006) begin
            errors++; $display("FAIL flush_after valid=%0b pc=%h instr=%h exp 1/00007000/20060006",
                               id_valid, id_pc, id_instr);
        end
        $display("flush: post-flush head pc=%h instr=%h", id_pc, id_instr);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_ext_op();
        logic [31:0] instr_tab [6];
        logic        ext_tab   [6];
        instr_tab[0] = 32'h3421_FFFF; ext_tab[0] = 1'b0;  // ori
        instr_tab[1] = 32'h8C21_FFFF; ext_tab[1] = 1'b1;  // lw (0x23)
        instr_tab[2] = 32'h3021_FFFF; ext_tab[2] = 1'b0;  // andi
        instr_tab[3] = 32'h3821_FFFF; ext_tab[3] = 1'b0;  // xori
        instr_tab[4] = 32'h2C21_FFFF; ext_tab[4] = 1'b1;  // 0x0B
        instr_tab[5] = 32'h4021_FFFF; ext_tab[5] = 1'b1;  // 0x10
        for (int i = 0; i < 6; i++) begin
            if_valid = 1'b1; if_pc = 32'h0000_8000 + 32'(4 * i); if_instr = instr_tab[i];
            step();
            if_valid = 1'b0;
            checks++;
            if (id_ext_op !== ext_tab[i] || id_imm_16 !== 16'hFFFF || id_rs !== 5'd1 || id_rt !== 5'd1) begin
                errors++; $display("FAIL ext_op[%0d] instr=%h ext=%0b imm=%h rs=%0d rt=%0d exp ext=%0b imm=ffff rs=1 rt=1",
                                   i, id_instr, id_ext_op, id_imm_16, id_rs, id_rt, ext_tab[i]);
            end
            $display("ext_op[%0d]: instr=%h ext_op=%0b", i, id_instr, id_ext_op);
            id_ready = 1'b1;
            step();
            id_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_single_push();
        test_fill();
        test_stream();
        test_flush();
        test_ext_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
